// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter: access size encoding and FSM states.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE  = 2'd0,
        SIZE_HALF  = 2'd1,
        SIZE_WORD  = 2'd2,
        SIZE_DWORD = 2'd3
    } access_size_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RSP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle of mem_arbiter.
// slave = arbiter side, master = environment (fetch unit, data unit, memory).
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);

    logic                  if_req_i;
    logic [ADDR_WIDTH-1:0] if_addr_i;
    access_size_t          if_size_i;
    logic                  if_gnt_o;
    logic                  if_rsp_valid_o;

    logic                  dm_rd_req_i;
    logic                  dm_wr_req_i;
    logic [ADDR_WIDTH-1:0] dm_addr_i;
    logic [DATA_WIDTH-1:0] dm_wdata_i;
    access_size_t          dm_size_i;
    logic                  dm_gnt_o;
    logic                  dm_rsp_valid_o;

    logic [DATA_WIDTH-1:0] rsp_data_o;

    logic                  mem_rd_req_valid_o;
    logic                  mem_wr_req_valid_o;
    logic                  mem_req_is_instr_o;
    logic [ADDR_WIDTH-1:0] mem_req_addr_o;
    logic [DATA_WIDTH-1:0] mem_wr_data_o;
    access_size_t          mem_req_size_o;
    logic                  mem_rsp_valid_i;
    logic [DATA_WIDTH-1:0] mem_rsp_data_i;

    modport slave (
        input  if_req_i, if_addr_i, if_size_i,
        input  dm_rd_req_i, dm_wr_req_i, dm_addr_i, dm_wdata_i, dm_size_i,
        input  mem_rsp_valid_i, mem_rsp_data_i,
        output if_gnt_o, if_rsp_valid_o, dm_gnt_o, dm_rsp_valid_o, rsp_data_o,
        output mem_rd_req_valid_o, mem_wr_req_valid_o, mem_req_is_instr_o,
        output mem_req_addr_o, mem_wr_data_o, mem_req_size_o
    );

    modport master (
        output if_req_i, if_addr_i, if_size_i,
        output dm_rd_req_i, dm_wr_req_i, dm_addr_i, dm_wdata_i, dm_size_i,
        output mem_rsp_valid_i, mem_rsp_data_i,
        input  if_gnt_o, if_rsp_valid_o, dm_gnt_o, dm_rsp_valid_o, rsp_data_o,
        input  mem_rd_req_valid_o, mem_wr_req_valid_o, mem_req_is_instr_o,
        input  mem_req_addr_o, mem_wr_data_o, mem_req_size_o
    );

endinterface

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter between instruction fetch and data requests onto one memory port.
// Optional grant counters (perf_if_grants_o / perf_dm_grants_o) are built with MEM_ARB_PERF_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mem_arbiter_if.slave  bus
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]   perf_if_grants_o,
    output logic [31:0]   perf_dm_grants_o
`endif
);

    localparam int unsigned CNT_W   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t            state_q, state_d;
    logic [CNT_W-1:0]      starve_q, starve_d;
    logic                  owner_instr_q, owner_instr_d;
    logic                  is_wr_q, is_wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    access_size_t          size_q, size_d;

    logic dm_req;
    logic fetch_wins;

    // Data has priority unless fetch has waited through STARVE_LIMIT data grants.
    assign dm_req     = bus.dm_rd_req_i | bus.dm_wr_req_i;
    assign fetch_wins = bus.if_req_i & (~dm_req | (starve_q == CNT_MAX));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= ST_IDLE;
            starve_q      <= '0;
            owner_instr_q <= 1'b0;
            is_wr_q       <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            size_q        <= SIZE_BYTE;
        end else begin
            state_q       <= state_d;
            starve_q      <= starve_d;
            owner_instr_q <= owner_instr_d;
            is_wr_q       <= is_wr_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            size_q        <= size_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        starve_d      = starve_q;
        owner_instr_d = owner_instr_q;
        is_wr_d       = is_wr_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        size_d        = size_q;

        bus.if_gnt_o           = 1'b0;
        bus.dm_gnt_o           = 1'b0;
        bus.if_rsp_valid_o     = 1'b0;
        bus.dm_rsp_valid_o     = 1'b0;
        bus.rsp_data_o         = '0;
        bus.mem_rd_req_valid_o = 1'b0;
        bus.mem_wr_req_valid_o = 1'b0;
        bus.mem_req_is_instr_o = 1'b0;
        bus.mem_req_addr_o     = '0;
        bus.mem_wr_data_o      = '0;
        bus.mem_req_size_o     = SIZE_BYTE;

        unique case (state_q)
            // Grants are combinational, so they are gated while reset is held.
            ST_IDLE: begin
                if (rst_i) begin
                    if (fetch_wins) begin
                        bus.if_gnt_o  = 1'b1;
                        owner_instr_d = 1'b1;
                        is_wr_d       = 1'b0;
                        addr_d        = bus.if_addr_i;
                        wdata_d       = '0;
                        size_d        = bus.if_size_i;
                        starve_d      = '0;
                        state_d       = ST_ISSUE;
                    end else if (dm_req) begin
                        bus.dm_gnt_o  = 1'b1;
                        owner_instr_d = 1'b0;
                        is_wr_d       = bus.dm_wr_req_i;
                        addr_d        = bus.dm_addr_i;
                        wdata_d       = bus.dm_wr_req_i ? bus.dm_wdata_i : '0;
                        size_d        = bus.dm_size_i;
                        if (bus.if_req_i && (starve_q != CNT_MAX)) begin
                            starve_d = starve_q + CNT_W'(1);
                        end
                        state_d       = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                bus.mem_rd_req_valid_o = ~is_wr_q;
                bus.mem_wr_req_valid_o = is_wr_q;
                bus.mem_req_is_instr_o = owner_instr_q;
                bus.mem_req_addr_o     = addr_q;
                bus.mem_wr_data_o      = wdata_q;
                bus.mem_req_size_o     = size_q;
                state_d                = ST_WAIT_RSP;
            end
            ST_WAIT_RSP: begin
                if (bus.mem_rsp_valid_i) begin
                    bus.if_rsp_valid_o = owner_instr_q;
                    bus.dm_rsp_valid_o = ~owner_instr_q;
                    bus.rsp_data_o     = bus.mem_rsp_data_i;
                    state_d            = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_q, perf_if_d;
    logic [31:0] perf_dm_q, perf_dm_d;

    always_comb begin
        perf_if_d = perf_if_q + 32'(bus.if_gnt_o);
        perf_dm_d = perf_dm_q + 32'(bus.dm_gnt_o);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            perf_if_q <= '0;
            perf_dm_q <= '0;
        end else begin
            perf_if_q <= perf_if_d;
            perf_dm_q <= perf_dm_d;
        end
    end

    assign perf_if_grants_o = perf_if_q;
    assign perf_dm_grants_o = perf_dm_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned AW     = 32;
    localparam int unsigned DW     = 32;
    localparam int unsigned STARVE = 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if;
    logic [31:0] perf_dm;
`endif

    mem_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .STARVE_LIMIT(STARVE)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .bus  (bus)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_if_grants_o(perf_if),
        .perf_dm_grants_o(perf_dm)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {if_gnt, dm_gnt}
    function automatic logic [1:0] gnt_bus();
        return {bus.if_gnt_o, bus.dm_gnt_o};
    endfunction

    // {rd, wr, instr, addr, wdata, size}
    function automatic logic [69:0] mem_bus();
        return {bus.mem_rd_req_valid_o, bus.mem_wr_req_valid_o, bus.mem_req_is_instr_o,
                bus.mem_req_addr_o, bus.mem_wr_data_o, bus.mem_req_size_o};
    endfunction

    // {if_rsp, dm_rsp, data}
    function automatic logic [33:0] rsp_bus();
        return {bus.if_rsp_valid_o, bus.dm_rsp_valid_o, bus.rsp_data_o};
    endfunction

    task automatic idle_inputs();
        bus.if_req_i        = 1'b0;
        bus.if_addr_i       = '0;
        bus.if_size_i       = SIZE_BYTE;
        bus.dm_rd_req_i     = 1'b0;
        bus.dm_wr_req_i     = 1'b0;
        bus.dm_addr_i       = '0;
        bus.dm_wdata_i      = '0;
        bus.dm_size_i       = SIZE_BYTE;
        bus.mem_rsp_valid_i = 1'b0;
        bus.mem_rsp_data_i  = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        idle_inputs();
        sample();
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        bus.if_req_i        = 1'b1;
        bus.dm_rd_req_i     = 1'b1;
        bus.mem_rsp_valid_i = 1'b1;
        bus.mem_rsp_data_i  = 32'hFFFF_0000;
        next_cycle();
        sample();
        n_cmp++;
        if ({gnt_bus(), mem_bus(), rsp_bus()} !== 106'd0) begin
            n_err++;
            $display("FAIL reset_hold: got %h expected all zero", {gnt_bus(), mem_bus(), rsp_bus()});
        end
        next_cycle();
        rst_n = 1'b1;
        idle_inputs();
        sample();
        n_cmp++;
        if ({gnt_bus(), mem_bus(), rsp_bus()} !== 106'd0) begin
            n_err++;
            $display("FAIL reset_idle: got %h expected all zero", {gnt_bus(), mem_bus(), rsp_bus()});
        end
        next_cycle();
    endtask

    task automatic test_fetch();
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h100;
        bus.if_size_i = SIZE_WORD;
        sample();
        n_cmp++;
        if (gnt_bus() !== 2'b10) begin
            n_err++;
            $display("FAIL fetch_gnt: got %b expected 10", gnt_bus());
        end
        next_cycle();
        idle_inputs();
        bus.if_addr_i = 32'hFFFF_FFFF;
        sample();
        n_cmp++;
        if (mem_bus() !== {3'b101, 32'h100, 32'h0, SIZE_WORD}) begin
            n_err++;
            $display("FAIL fetch_memreq: got %h expected %h", mem_bus(), {3'b101, 32'h100, 32'h0, SIZE_WORD});
        end
        next_cycle();
        idle_inputs();
        bus.if_req_i = 1'b1;
        sample();
        n_cmp++;
        if ({gnt_bus(), mem_bus(), rsp_bus()} !== 106'd0) begin
            n_err++;
            $display("FAIL fetch_wait_quiet: got %h expected all zero", {gnt_bus(), mem_bus(), rsp_bus()});
        end
        next_cycle();
        idle_inputs();
        bus.mem_rsp_valid_i = 1'b1;
        bus.mem_rsp_data_i  = 32'hDEAD_BEEF;
        sample();
        n_cmp++;
        if (rsp_bus() !== {2'b10, 32'hDEAD_BEEF}) begin
            n_err++;
            $display("FAIL fetch_rsp: got %h expected %h", rsp_bus(), {2'b10, 32'hDEAD_BEEF});
        end
        next_cycle();
        idle_inputs();
        sample();
        n_cmp++;
        if (rsp_bus() !== 34'd0) begin
            n_err++;
            $display("FAIL fetch_rsp_one_cycle: got %h expected 0", rsp_bus());
        end
        next_cycle();
    endtask

    task automatic test_starvation();
        logic [1:0] exp_gnt;
        pulse_reset();
        for (int k = 0; k < 7; k++) begin
            exp_gnt = (k == 4) ? 2'b10 : 2'b01;
            bus.if_req_i    = 1'b1;
            bus.dm_rd_req_i = 1'b1;
            bus.if_addr_i   = 32'h1000 + AW'(k);
            bus.dm_addr_i   = 32'h2000 + AW'(k);
            sample();
            n_cmp++;
            if (gnt_bus() !== exp_gnt) begin
                n_err++;
                $display("FAIL starve_gnt[%0d]: got %b expected %b", k, gnt_bus(), exp_gnt);
            end
            next_cycle();
            sample();
            n_cmp++;
            if (gnt_bus() !== 2'b00) begin
                n_err++;
                $display("FAIL starve_no_gnt_issue[%0d]: got %b expected 00", k, gnt_bus());
            end
            next_cycle();
            bus.mem_rsp_valid_i = 1'b1;
            bus.mem_rsp_data_i  = 32'h5000 + DW'(k);
            sample();
            n_cmp++;
            if ({gnt_bus(), rsp_bus()} !== {2'b00, exp_gnt, 32'h5000 + DW'(k)}) begin
                n_err++;
                $display("FAIL starve_rsp[%0d]: got %h expected %h", k, {gnt_bus(), rsp_bus()},
                         {2'b00, exp_gnt, 32'h5000 + DW'(k)});
            end
            next_cycle();
            bus.mem_rsp_valid_i = 1'b0;
        end
        idle_inputs();
    endtask

    task automatic test_write();
        pulse_reset();
        bus.dm_wr_req_i = 1'b1;
        bus.dm_addr_i   = 32'h40;
        bus.dm_wdata_i  = 32'h1234_5678;
        bus.dm_size_i   = SIZE_WORD;
        sample();
        n_cmp++;
        if (gnt_bus() !== 2'b01) begin
            n_err++;
            $display("FAIL write_gnt: got %b expected 01", gnt_bus());
        end
        next_cycle();
        idle_inputs();
        bus.dm_addr_i = 32'h99;
        sample();
        n_cmp++;
        if (mem_bus() !== {3'b010, 32'h40, 32'h1234_5678, SIZE_WORD}) begin
            n_err++;
            $display("FAIL write_memreq: got %h expected %h", mem_bus(), {3'b010, 32'h40, 32'h1234_5678, SIZE_WORD});
        end
        next_cycle();
        sample();
        n_cmp++;
        if ({mem_bus(), rsp_bus()} !== 104'd0) begin
            n_err++;
            $display("FAIL write_single_pulse: got %h expected 0", {mem_bus(), rsp_bus()});
        end
        next_cycle();
        bus.mem_rsp_valid_i = 1'b1;
        bus.mem_rsp_data_i  = 32'hA5A5_0001;
        sample();
        n_cmp++;
        if (rsp_bus() !== {2'b01, 32'hA5A5_0001}) begin
            n_err++;
            $display("FAIL write_ack: got %h expected %h", rsp_bus(), {2'b01, 32'hA5A5_0001});
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        bus.dm_rd_req_i = 1'b1;
        bus.dm_addr_i   = 32'h80;
        sample();
        next_cycle();
        idle_inputs();
        sample();
        n_cmp++;
        if (mem_bus() !== {3'b100, 32'h80, 32'h0, SIZE_BYTE}) begin
            n_err++;
            $display("FAIL rstmid_memreq: got %h expected %h", mem_bus(), {3'b100, 32'h80, 32'h0, SIZE_BYTE});
        end
        next_cycle();
        rst_n = 1'b0;
        sample();
        n_cmp++;
        if ({gnt_bus(), mem_bus(), rsp_bus()} !== 106'd0) begin
            n_err++;
            $display("FAIL rstmid_hold: got %h expected all zero", {gnt_bus(), mem_bus(), rsp_bus()});
        end
        next_cycle();
        rst_n = 1'b1;
        bus.mem_rsp_valid_i = 1'b1;
        bus.mem_rsp_data_i  = 32'h55;
        sample();
        n_cmp++;
        if ({gnt_bus(), mem_bus(), rsp_bus()} !== 106'd0) begin
            n_err++;
            $display("FAIL rstmid_late_rsp: got %h expected all zero", {gnt_bus(), mem_bus(), rsp_bus()});
        end
        next_cycle();
        idle_inputs();
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h200;
        sample();
        n_cmp++;
        if (gnt_bus() !== 2'b10) begin
            n_err++;
            $display("FAIL rstmid_regrant: got %b expected 10", gnt_bus());
        end
        next_cycle();
        idle_inputs();
        sample();
        n_cmp++;
        if (mem_bus() !== {3'b101, 32'h200, 32'h0, SIZE_BYTE}) begin
            n_err++;
            $display("FAIL rstmid_re_memreq: got %h expected %h", mem_bus(), {3'b101, 32'h200, 32'h0, SIZE_BYTE});
        end
        next_cycle();
        bus.mem_rsp_valid_i = 1'b1;
        bus.mem_rsp_data_i  = 32'h0BAD_F00D;
        sample();
        n_cmp++;
        if (rsp_bus() !== {2'b10, 32'h0BAD_F00D}) begin
            n_err++;
            $display("FAIL rstmid_re_rsp: got %h expected %h", rsp_bus(), {2'b10, 32'h0BAD_F00D});
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_rdwr_conflict();
        bus.mem_rsp_valid_i = 1'b1;
        bus.mem_rsp_data_i  = 32'h7777_7777;
        sample();
        n_cmp++;
        if ({gnt_bus(), mem_bus(), rsp_bus()} !== 106'd0) begin
            n_err++;
            $display("FAIL stray_rsp_idle: got %h expected all zero", {gnt_bus(), mem_bus(), rsp_bus()});
        end
        next_cycle();
        bus.dm_rd_req_i = 1'b1;
        bus.dm_wr_req_i = 1'b1;
        bus.dm_addr_i   = 32'h44;
        bus.dm_wdata_i  = 32'hCAFE_F00D;
        bus.dm_size_i   = SIZE_HALF;
        sample();
        n_cmp++;
        if ({gnt_bus(), rsp_bus()} !== {2'b01, 34'd0}) begin
            n_err++;
            $display("FAIL rdwr_gnt: got %h expected %h", {gnt_bus(), rsp_bus()}, {2'b01, 34'd0});
        end
        next_cycle();
        bus.dm_rd_req_i = 1'b0;
        bus.dm_wr_req_i = 1'b0;
        sample();
        n_cmp++;
        if ({mem_bus(), rsp_bus()} !== {3'b010, 32'h44, 32'hCAFE_F00D, SIZE_HALF, 34'd0}) begin
            n_err++;
            $display("FAIL rdwr_memreq: got %h expected %h", {mem_bus(), rsp_bus()},
                     {3'b010, 32'h44, 32'hCAFE_F00D, SIZE_HALF, 34'd0});
        end
        next_cycle();
        bus.mem_rsp_data_i = 32'h0000_ACED;
        sample();
        n_cmp++;
        if (rsp_bus() !== {2'b01, 32'h0000_ACED}) begin
            n_err++;
            $display("FAIL rdwr_ack: got %h expected %h", rsp_bus(), {2'b01, 32'h0000_ACED});
        end
        next_cycle();
        idle_inputs();
    endtask

    // Transaction-level model: one slot, aged in cycles since its grant.
    task automatic test_random();
        bit              busy;
        int              age;
        int              starve;
        bit              t_instr, t_wr;
        logic [AW-1:0]   t_addr;
        logic [DW-1:0]   t_wdata;
        access_size_t    t_size;
        bit              dm_any, eg_if, eg_dm;
        logic [1:0]      exp_gnt;
        logic [69:0]     exp_mem;
        logic [33:0]     exp_rsp;
        pulse_reset();
        busy = 0; age = 0; starve = 0;
        t_instr = 0; t_wr = 0; t_addr = '0; t_wdata = '0; t_size = SIZE_BYTE;
        for (int c = 0; c < 3000; c++) begin
            rst_n               = ($urandom_range(0, 99) != 0);
            bus.if_req_i        = ($urandom_range(0, 9) < 6);
            bus.if_addr_i       = $urandom;
            bus.if_size_i       = access_size_t'($urandom_range(0, 3));
            bus.dm_rd_req_i     = ($urandom_range(0, 1) == 1);
            bus.dm_wr_req_i     = ($urandom_range(0, 9) < 3);
            bus.dm_addr_i       = $urandom;
            bus.dm_wdata_i      = $urandom;
            bus.dm_size_i       = access_size_t'($urandom_range(0, 3));
            bus.mem_rsp_valid_i = ($urandom_range(0, 9) < 4);
            bus.mem_rsp_data_i  = $urandom;

            dm_any  = bus.dm_rd_req_i || bus.dm_wr_req_i;
            eg_if   = rst_n && !busy && bus.if_req_i && (!dm_any || starve >= int'(STARVE));
            eg_dm   = rst_n && !busy && !eg_if && dm_any;
            exp_gnt = {eg_if, eg_dm};
            exp_mem = '0;
            exp_rsp = '0;
            if (rst_n && busy && age == 1)
                exp_mem = {!t_wr, t_wr, t_instr, t_addr, t_wr ? t_wdata : 32'h0, t_size};
            if (rst_n && busy && age >= 2 && bus.mem_rsp_valid_i)
                exp_rsp = {t_instr, !t_instr, bus.mem_rsp_data_i};

            sample();
            n_cmp++;
            if (gnt_bus() !== exp_gnt) begin
                n_err++;
                $display("FAIL rand_gnt cycle %0d: got %b expected %b", c, gnt_bus(), exp_gnt);
            end
            n_cmp++;
            if (mem_bus() !== exp_mem) begin
                n_err++;
                $display("FAIL rand_mem cycle %0d: got %h expected %h", c, mem_bus(), exp_mem);
            end
            n_cmp++;
            if (rsp_bus() !== exp_rsp) begin
                n_err++;
                $display("FAIL rand_rsp cycle %0d: got %h expected %h", c, rsp_bus(), exp_rsp);
            end

            if (!rst_n) begin
                busy   = 0;
                starve = 0;
            end else if (busy) begin
                if (age >= 2 && bus.mem_rsp_valid_i) busy = 0;
                else age++;
            end else if (eg_if || eg_dm) begin
                busy    = 1;
                age     = 1;
                t_instr = eg_if;
                t_wr    = eg_dm && bus.dm_wr_req_i;
                t_addr  = eg_if ? bus.if_addr_i : bus.dm_addr_i;
                t_size  = eg_if ? bus.if_size_i : bus.dm_size_i;
                t_wdata = t_wr ? bus.dm_wdata_i : '0;
                if (eg_if) starve = 0;
                else if (bus.if_req_i && starve < int'(STARVE)) starve++;
            end
            next_cycle();
        end
        rst_n = 1'b1;
        idle_inputs();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_fetch();
        test_starvation();
        test_write();
        test_reset_mid();
        test_rdwr_conflict();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: width of request address.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: width of write/read data.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4: consecutive data grants tolerated while an instruction request waits.
REQ-004 SHALL have ports:
- clk_i  in  1  single clock
- rst_i  in  1  asynchronous, active-low reset
- if_req_i  in  1  fetch read request
- if_addr_i  in  ADDR_WIDTH  fetch address
- if_size_i  in  access_size_t  fetch access size
- if_gnt_o  out  1  fetch request accepted
- if_rsp_valid_o  out  1  instruction data valid
- dm_rd_req_i  in  1  data read request
- dm_wr_req_i  in  1  data write request
- dm_addr_i  in  ADDR_WIDTH  data address
- dm_wdata_i  in  DATA_WIDTH  store data
- dm_size_i  in  access_size_t  data access size
- dm_gnt_o  out  1  data request accepted
- dm_rsp_valid_o  out  1  load data / store ack valid
- rsp_data_o  out  DATA_WIDTH  response data, shared by both requesters
- mem_rd_req_valid_o  out  1  memory read request
- mem_wr_req_valid_o  out  1  memory write request
- mem_req_is_instr_o  out  1  request belongs to fetch
- mem_req_addr_o  out  ADDR_WIDTH  memory address
- mem_wr_data_o  out  DATA_WIDTH  memory write data
- mem_req_size_o  out  access_size_t  memory access size
- mem_rsp_valid_i  in  1  memory response (one per request, reads and writes)
- mem_rsp_data_i  in  DATA_WIDTH  memory read data

Function
REQ-005 SHALL be an FSM with states IDLE, ISSUE, WAIT_RSP; at most one memory transaction outstanding.
REQ-006 In IDLE, when any request is present, SHALL assert exactly one of if_gnt_o/dm_gnt_o combinationally in that cycle and move to ISSUE.
REQ-007 SHALL give data requests priority, except when starve_cnt equals STARVE_LIMIT and if_req_i is high; then fetch SHALL win.
REQ-008 starve_cnt SHALL increment on each dm grant while if_req_i is high, saturate at STARVE_LIMIT, and clear on each if grant.
REQ-009 dm_rd_req_i and dm_wr_req_i both high SHALL be treated as a write only.
REQ-010 On grant, SHALL register address, size, write data, type and owner tag; requesters may change inputs the cycle after grant.
REQ-011 In ISSUE, SHALL drive exactly one of mem_rd_req_valid_o/mem_wr_req_valid_o high for one cycle, with the registered fields stable, then enter WAIT_RSP.
REQ-012 mem_req_is_instr_o SHALL be high only during ISSUE of a fetch transaction.
REQ-013 In WAIT_RSP, on mem_rsp_valid_i, SHALL pulse if_rsp_valid_o or dm_rsp_valid_o per owner tag for one cycle with rsp_data_o = mem_rsp_data_i (combinational), and return to IDLE.
REQ-014 Minimum turnaround SHALL be grant (cycle 0), mem request (cycle 1), response (cycle 2 or later), next grant (cycle after response).
REQ-015 mem_rsp_valid_i in IDLE or ISSUE SHALL be ignored; no rsp_valid is produced.
REQ-016 No grant SHALL be issued in ISSUE or WAIT_RSP, even when requests are pending.
REQ-017 Memory outputs and rsp_data_o SHALL be zero whenever the corresponding valid is low.

Reset
REQ-018 While rst_i is low, SHALL go to IDLE, clear starve_cnt, owner tag and registered fields, and hold all outputs at 0.
REQ-019 Reset during ISSUE or WAIT_RSP SHALL abandon the transaction; a response arriving after reset release SHALL be ignored per REQ-015.

Configuration
REQ-020 With macro MEM_ARB_PERF_EN defined, SHALL add outputs perf_if_grants_o and perf_dm_grants_o (32 bits each): wrapping counters of grants, reset to 0, incremented on each grant.
REQ-021 Without MEM_ARB_PERF_EN, these ports and counters SHALL be absent; all other behaviour is identical.

Verification
REQ-022 Only if_req_i=1, if_addr_i=0x100; memory responds 2 cycles after the request with 0xDEADBEEF -> if_gnt_o at cycle 0; mem_rd_req_valid_o=1 with mem_req_is_instr_o=1 and addr 0x100 at cycle 1; if_rsp_valid_o=1 with rsp_data_o=0xDEADBEEF at cycle 3.
REQ-023 if_req_i and dm_rd_req_i both held high, STARVE_LIMIT=4 -> exactly 4 dm grants, then 1 if grant, then dm again.
REQ-024 dm_wr_req_i=1, addr 0x40, wdata 0x12345678 -> mem_wr_req_valid_o=1 for exactly one cycle with those values; dm_rsp_valid_o only on the ack.
REQ-025 rst_i pulsed low in WAIT_RSP, then mem_rsp_valid_i=1 -> no rsp_valid pulse, all outputs 0, and the next request is granted normally.
REQ-026 dm_rd_req_i=dm_wr_req_i=1 -> only mem_wr_req_valid_o asserted; a stray mem_rsp_valid_i in IDLE produces no response.
